// File: rtl/fir_sample_sink.sv
// +--------------------------------------------------------------------------+
// | fir_sample_sink: captures FIR results, decimates, buffers in a FWFT FIFO |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_sample_sink #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16,
    parameter int DECIM = 1,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     done_i,
    input  logic [WIDTH-1:0]         sample_i,
    input  logic                     clear_i,
    output logic                     m_valid_o,
    output logic [WIDTH-1:0]         m_data_o,
    input  logic                     m_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_count_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [c_DW-1:0] c_DEC_LAST = c_DW'(DECIM - 1);
    localparam logic [c_AW:0]   c_FULL     = DEPTH[c_AW:0];

    logic                done_q;
    logic [c_DW-1:0]     dec_cnt_q, dec_cnt_d;
    logic [c_AW:0]       wr_ptr_q, wr_ptr_d;
    logic [c_AW:0]       rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];

    logic [c_AW:0]       w_level;
    logic                w_full;
    logic                w_pop;
    logic                w_keep;
    logic                w_push;
    logic                w_drop;

    always_comb begin
        w_level = wr_ptr_q - rd_ptr_q;
        w_full  = (w_level == c_FULL);
        w_pop   = (w_level != '0) && m_ready_i;
        w_keep  = done_q && (dec_cnt_q == '0);
        // A pop in the same cycle frees the slot the kept sample needs.
        w_push  = w_keep && (!w_full || w_pop);
        w_drop  = w_keep && w_full && !w_pop;

        dec_cnt_d  = dec_cnt_q;
        if (done_q) begin
            dec_cnt_d = (dec_cnt_q == c_DEC_LAST) ? '0 : dec_cnt_q + 1'b1;
        end
        wr_ptr_d   = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q || w_drop;
        drop_cnt_d = drop_cnt_q;
        if (w_drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q     <= 1'b0;
            dec_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clear_i) begin
            done_q     <= 1'b0;
            dec_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            done_q     <= done_i;
            dec_cnt_q  <= dec_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; emptiness is defined purely by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_push && !clear_i) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= sample_i;
        end
    end

    assign m_valid_o    = (w_level != '0);
    assign m_data_o     = m_valid_o ? mem_q[rd_ptr_q[c_AW-1:0]] : '0;
    assign level_o      = w_level;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_sample_sink.sv
// +--------------------------------------------------------------------------+
// | tb_fir_sample_sink: model-checked bench for two sink configurations      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fir_sample_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done_i = 1'b0;
    logic [23:0] sample_i = '0;
    logic        clear_i = 1'b0;
    logic        ready_i = 1'b0;

    logic        a_valid, b_valid;
    logic [23:0] a_data, b_data;
    logic [4:0]  a_level;
    logic [2:0]  b_level;
    logic        a_ovf, b_ovf;
    logic [15:0] a_drops;
    logic [3:0]  b_drops;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fir_sample_sink #(.WIDTH(24), .DEPTH(16), .DECIM(1), .CNT_W(16)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .done_i(done_i), .sample_i(sample_i),
        .clear_i(clear_i), .m_valid_o(a_valid), .m_data_o(a_data),
        .m_ready_i(ready_i), .level_o(a_level), .overflow_o(a_ovf),
        .drop_count_o(a_drops)
    );

    fir_sample_sink #(.WIDTH(24), .DEPTH(4), .DECIM(4), .CNT_W(4)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .done_i(done_i), .sample_i(sample_i),
        .clear_i(clear_i), .m_valid_o(b_valid), .m_data_o(b_data),
        .m_ready_i(ready_i), .level_o(b_level), .overflow_o(b_ovf),
        .drop_count_o(b_drops)
    );

    // Reference model: index 0 mirrors DUT A, index 1 mirrors DUT B.
    int          m_cnt   [2];
    int          m_head  [2];
    int          m_phase [2];
    int          m_drops [2];
    bit          m_ovf   [2];
    bit          m_dprev [2];
    logic [23:0] m_buf   [2][64];

    function automatic int depth_of(input int k);
        return (k == 0) ? 16 : 4;
    endfunction
    function automatic int decim_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction
    function automatic int cmax_of(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic logic [31:0] exp_data(input int k);
        return (m_cnt[k] != 0) ? 32'(m_buf[k][m_head[k]]) : 32'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_head[k] = 0; m_phase[k] = 0;
            m_drops[k] = 0; m_ovf[k] = 1'b0; m_dprev[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int  c0;
        int  h0;
        bit  pop;
        bit  keep;
        bit  push;
        c0   = m_cnt[k];
        h0   = m_head[k];
        pop  = (c0 != 0) && ready_i;
        if (clear_i) begin
            m_cnt[k] = 0; m_head[k] = 0; m_phase[k] = 0;
            m_drops[k] = 0; m_ovf[k] = 1'b0; m_dprev[k] = 1'b0;
        end else begin
            keep = m_dprev[k] && (m_phase[k] == 0);
            if (m_dprev[k]) m_phase[k] = (m_phase[k] + 1) % decim_of(k);
            push = keep && ((c0 < depth_of(k)) || pop);
            if (push) m_buf[k][(h0 + c0) % 64] = sample_i;
            if (keep && !push) begin
                m_ovf[k] = 1'b1;
                if (m_drops[k] < cmax_of(k)) m_drops[k]++;
            end
            m_head[k]  = pop ? (h0 + 1) % 64 : h0;
            m_cnt[k]   = c0 + int'(push) - int'(pop);
            m_dprev[k] = done_i;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("A.valid", 32'(a_valid), 32'(m_cnt[0] != 0));
        check("A.data",  32'(a_data),  exp_data(0));
        check("A.level", 32'(a_level), 32'(m_cnt[0]));
        check("A.ovf",   32'(a_ovf),   32'(m_ovf[0]));
        check("A.drops", 32'(a_drops), 32'(m_drops[0]));
        check("B.valid", 32'(b_valid), 32'(m_cnt[1] != 0));
        check("B.data",  32'(b_data),  exp_data(1));
        check("B.level", 32'(b_level), 32'(m_cnt[1]));
        check("B.ovf",   32'(b_ovf),   32'(m_ovf[1]));
        check("B.drops", 32'(b_drops), 32'(m_drops[1]));
    end

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic cyc(input bit d, input logic [23:0] s, input bit clr, input bit rdy);
        done_i = d; sample_i = s; clear_i = clr; ready_i = rdy;
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        #1;
    endtask

    task automatic send(input logic [23:0] v, input bit rdy_on_capture);
        cyc(1'b1, 24'd0, 1'b0, 1'b0);
        cyc(1'b0, v, 1'b0, rdy_on_capture);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.A.valid", 32'(a_valid), 32'd0);
        check("rst.A.level", 32'(a_level), 32'd0);
        check("rst.A.ovf",   32'(a_ovf),   32'd0);
        check("rst.A.drops", 32'(a_drops), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Async reset with data buffered
        cyc(1'b0, 24'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send(24'(i + 9), 1'b0);
        check("lvl5.A.level", 32'(a_level), 32'd5);
        async_reset();

        // Single sample latency
        cyc(1'b1, 24'd0, 1'b0, 1'b1);
        cyc(1'b0, 24'h123456, 1'b0, 1'b1);
        check("single.valid", 32'(a_valid), 32'd1);
        check("single.data",  32'(a_data),  32'h123456);
        cyc(1'b0, 24'd0, 1'b0, 1'b1);
        check("single.level", 32'(a_level), 32'd0);

        // Overflow with back-to-back pulses 1..20
        cyc(1'b0, 24'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 21; i++) cyc(i <= 20, 24'(i - 1), 1'b0, 1'b0);
        check("ovf.level", 32'(a_level), 32'd16);
        check("ovf.flag",  32'(a_ovf),   32'd1);
        check("ovf.drops", 32'(a_drops), 32'd4);
        for (int i = 1; i <= 16; i++) begin
            check("drain.data", 32'(a_data), 32'(i));
            cyc(1'b0, 24'd0, 1'b0, 1'b1);
        end
        check("drain.empty", 32'(a_valid), 32'd0);

        // Full FIFO with pop on the capture cycle
        cyc(1'b0, 24'd0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) send(24'(101 + i), 1'b0);
        send(24'd200, 1'b1);
        check("fullpop.level", 32'(a_level), 32'd16);
        check("fullpop.drops", 32'(a_drops), 32'd0);
        check("fullpop.head",  32'(a_data),  32'd102);
        for (int i = 0; i < 15; i++) cyc(1'b0, 24'd0, 1'b0, 1'b1);
        check("fullpop.last",  32'(a_data),  32'd200);

        // Decimation by 4 with a negative sample
        cyc(1'b0, 24'd0, 1'b1, 1'b0);
        send(24'h800000, 1'b0);
        for (int i = 1; i <= 7; i++) send(24'(i), 1'b0);
        check("decim.level", 32'(b_level), 32'd2);
        check("decim.first", 32'(b_data),  32'h800000);
        cyc(1'b0, 24'd0, 1'b0, 1'b1);
        check("decim.second", 32'(b_data), 32'd4);

        // Counter saturation, then clear colliding with a capture
        cyc(1'b0, 24'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 81; i++) cyc(i <= 80, 24'(i - 1), 1'b0, 1'b0);
        check("sat.B.drops", 32'(b_drops), 32'd15);
        check("sat.B.ovf",   32'(b_ovf),   32'd1);
        check("sat.A.drops", 32'(a_drops), 32'd64);
        cyc(1'b1, 24'd0, 1'b0, 1'b0);
        cyc(1'b0, 24'h000555, 1'b1, 1'b0);
        check("clr.A.level", 32'(a_level), 32'd0);
        check("clr.A.ovf",   32'(a_ovf),   32'd0);
        check("clr.A.drops", 32'(a_drops), 32'd0);
        check("clr.B.drops", 32'(b_drops), 32'd0);
        cyc(1'b0, 24'd0, 1'b0, 1'b0);
        check("clr.lost",    32'(a_level), 32'd0);

        // Randomized traffic with varying downstream back-pressure
        for (int blk = 0; blk < 6; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
            for (int i = 0; i < 500; i++) begin
                if (blk == 3 && i == 250) async_reset();
                cyc(1'($urandom_range(0, 1)), 24'($urandom),
                    $urandom_range(0, 299) == 0,
                    $urandom_range(0, 99) < rdy_pct);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
